// File: rtl/mcpm_pkg.sv
// Shared types and constants for the multi-channel packet merger:
// word framing bit positions, FSM states and the register map.
package mcpm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam logic [7:0] ADDR_ID       = 8'h00;
    localparam logic [7:0] ADDR_MASK     = 8'h01;
    localparam logic [7:0] ADDR_STATUS   = 8'h02;
    localparam logic [7:0] ADDR_CNT_BASE = 8'h10;

    localparam logic [1:0] CNT_PKT  = 2'd0;
    localparam logic [1:0] CNT_DROP = 2'd1;
    localparam logic [1:0] CNT_ERR  = 2'd2;

    localparam logic [7:0] ID_TAG = 8'hA5;

    function automatic int sop_bit(input int data_w);
        return data_w + 3;
    endfunction

    function automatic int eop_bit(input int data_w);
        return data_w + 2;
    endfunction

    function automatic logic [31:0] id_word(input int n_ch, input int max_len);
        return {ID_TAG, 8'(n_ch), 16'(max_len)};
    endfunction

endpackage

// File: rtl/multi_channel_packet_merger_rr_arbiter.sv
// Combinational round-robin pick: the first requester after 'last',
// wrapping around, so the previous winner has the lowest priority.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any
);

    localparam int LW = $clog2(N);

    int idx;

    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last) + i) % N;
            if (!any && req[idx]) begin
                any     = 1'b1;
                gnt_idx = LW'(idx);
            end
        end
    end

endmodule

// File: rtl/multi_channel_packet_merger.sv
// Merges N_CH framed receive streams into one tagged DMA stream with
// round-robin at packet boundaries and forced truncation at MAX_LEN.
module multi_channel_packet_merger
    import mcpm_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int DATA_W  = 32,
    parameter int MAX_LEN = 1024,
    parameter int CNT_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_CH*(DATA_W+4)-1:0] i_in_data,
    input  logic [N_CH-1:0]            i_in_vld,
    output logic [N_CH-1:0]            o_in_rdy,
    output logic [DATA_W-1:0]          dma_data,
    output logic [$clog2(N_CH)-1:0]    dma_ch,
    output logic                       dma_sop,
    output logic                       dma_eop,
    output logic                       dma_vld,
    input  logic                       dma_rdy,
    input  logic [7:0]                 i_mm_addr,
    input  logic                       i_mm_rd,
    input  logic                       i_mm_wr,
    input  logic [31:0]                i_mm_wr_data,
    output logic [31:0]                o_mm_rd_data
);

    localparam int W     = DATA_W + 4;
    localparam int LW    = $clog2(N_CH);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int SOP_B = sop_bit(DATA_W);
    localparam int EOP_B = eop_bit(DATA_W);

    state_t           state, state_n;
    logic [LW-1:0]    grant, grant_n;
    logic [LW-1:0]    last_grant, last_n;
    logic [LW-1:0]    arb_idx, ch_idx;
    logic             arb_any;
    logic [N_CH-1:0]  mask, head_sop, req, orphan, in_rdy;
    logic [N_CH-1:0]  pkt_inc, drop_inc, err_inc;
    logic [W-1:0]     words [N_CH];
    logic [W-1:0]     g_word;
    logic [LEN_W-1:0] len, len_n;
    logic [CNT_W-1:0] pkt_cnt  [N_CH];
    logic [CNT_W-1:0] drop_cnt [N_CH];
    logic [CNT_W-1:0] err_cnt  [N_CH];
    logic             free, load, out_sop, out_eop;
    logic             g_vld, g_sop, g_eop;
    logic [7:0]       cnt_off;
    logic             cnt_hit;
    logic [31:0]      rd_mux;
    logic             unused_rsvd;

    always_comb begin
        unused_rsvd = ^i_mm_wr_data[31:N_CH];
        for (int i = 0; i < N_CH; i++) begin
            words[i]    = i_in_data[i*W +: W];
            head_sop[i] = words[i][SOP_B];
            unused_rsvd = unused_rsvd ^ (^words[i][DATA_W+1:DATA_W]);
        end
    end

    assign req    = mask & i_in_vld & head_sop;
    assign orphan = mask & i_in_vld & ~head_sop;
    assign g_word = words[grant];
    assign g_vld  = i_in_vld[grant];
    assign g_sop  = g_word[SOP_B];
    assign g_eop  = g_word[EOP_B];
    assign free   = ~dma_vld | dma_rdy;

    rr_arbiter #(.N(N_CH)) u_arb (
        .req     (req),
        .last    (last_grant),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    always_comb begin
        state_n  = state;
        grant_n  = grant;
        last_n   = last_grant;
        len_n    = len;
        in_rdy   = '0;
        load     = 1'b0;
        out_sop  = 1'b0;
        out_eop  = 1'b0;
        pkt_inc  = '0;
        drop_inc = '0;
        err_inc  = '0;
        unique case (state)
            IDLE: begin
                in_rdy   = orphan;
                drop_inc = orphan;
                if (arb_any) begin
                    grant_n = arb_idx;
                    len_n   = '0;
                    state_n = PASS;
                end
            end
            PASS: begin
                if (g_vld && free) begin
                    in_rdy[grant] = 1'b1;
                    load          = 1'b1;
                    len_n         = len + 1'b1;
                    out_sop       = (len == '0);
                    if (len != '0 && g_sop)
                        err_inc[grant] = 1'b1;
                    if (g_eop) begin
                        out_eop        = 1'b1;
                        pkt_inc[grant] = 1'b1;
                        last_n         = grant;
                        state_n        = IDLE;
                    end else if (len == LEN_W'(MAX_LEN - 1)) begin
                        // Truncate: close the packet here, discard the tail
                        out_eop        = 1'b1;
                        err_inc[grant] = 1'b1;
                        pkt_inc[grant] = 1'b1;
                        last_n         = grant;
                        state_n        = DROP;
                    end
                end
            end
            DROP: begin
                if (g_vld) begin
                    in_rdy[grant]   = 1'b1;
                    drop_inc[grant] = 1'b1;
                    if (g_eop)
                        state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign o_in_rdy = rst_n ? in_rdy : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= LW'(N_CH - 1);
            len        <= '0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            last_grant <= last_n;
            len        <= len_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dma_vld  <= 1'b0;
            dma_data <= '0;
            dma_ch   <= '0;
            dma_sop  <= 1'b0;
            dma_eop  <= 1'b0;
        end else if (load) begin
            dma_vld  <= 1'b1;
            dma_data <= g_word[DATA_W-1:0];
            dma_ch   <= grant;
            dma_sop  <= out_sop;
            dma_eop  <= out_eop;
        end else if (dma_rdy) begin
            dma_vld  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                pkt_cnt[i]  <= '0;
                drop_cnt[i] <= '0;
                err_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (pkt_inc[i] && pkt_cnt[i] != '1)
                    pkt_cnt[i] <= pkt_cnt[i] + 1'b1;
                if (drop_inc[i] && drop_cnt[i] != '1)
                    drop_cnt[i] <= drop_cnt[i] + 1'b1;
                if (err_inc[i] && err_cnt[i] != '1)
                    err_cnt[i] <= err_cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        cnt_off = i_mm_addr - ADDR_CNT_BASE;
        ch_idx  = cnt_off[LW+1:2];
        cnt_hit = (i_mm_addr >= ADDR_CNT_BASE) &&
                  ({2'b00, cnt_off[7:2]} < 8'(N_CH));
        rd_mux  = '0;
        if (i_mm_addr == ADDR_ID)
            rd_mux = id_word(N_CH, MAX_LEN);
        else if (i_mm_addr == ADDR_MASK)
            rd_mux = 32'(mask);
        else if (i_mm_addr == ADDR_STATUS)
            rd_mux = 32'({state, grant});
        else if (cnt_hit) begin
            unique case (cnt_off[1:0])
                CNT_PKT:  rd_mux = 32'(pkt_cnt[ch_idx]);
                CNT_DROP: rd_mux = 32'(drop_cnt[ch_idx]);
                CNT_ERR:  rd_mux = 32'(err_cnt[ch_idx]);
                default:  rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask         <= '1;
            o_mm_rd_data <= '0;
        end else begin
            if (i_mm_wr && i_mm_addr == ADDR_MASK)
                mask <= i_mm_wr_data[N_CH-1:0];
            if (i_mm_rd)
                o_mm_rd_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_multi_channel_packet_merger.sv
// Directed bench for the packet merger: channel FIFOs are modelled as
// queues, DMA beats are collected and compared to hand-derived values.
module tb_multi_channel_packet_merger;

    localparam int N_CH    = 4;
    localparam int DATA_W  = 32;
    localparam int MAX_LEN = 1024;
    localparam int CNT_W   = 32;
    localparam int W       = DATA_W + 4;

    typedef struct {
        logic [1:0]  ch;
        logic        sop;
        logic        eop;
        logic [31:0] data;
        int          cyc;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N_CH*W-1:0] i_in_data = '0;
    logic [N_CH-1:0]   i_in_vld = '0;
    logic [N_CH-1:0]   o_in_rdy;
    logic [31:0]       dma_data;
    logic [1:0]        dma_ch;
    logic              dma_sop, dma_eop, dma_vld;
    logic              dma_rdy = 1'b1;
    logic [7:0]        i_mm_addr = '0;
    logic              i_mm_rd = 1'b0;
    logic              i_mm_wr = 1'b0;
    logic [31:0]       i_mm_wr_data = '0;
    logic [31:0]       o_mm_rd_data;

    logic [W-1:0]    chq [N_CH][$];
    beat_t           obs [$];
    logic [N_CH-1:0] pop_mask = '0;
    logic [W-1:0]    popped;
    logic [35:0]     prev_out = '0;
    logic            prev_stall = 1'b0;
    logic            rdy0_seen = 1'b0;
    int              cyc = 0;
    int              n_checks = 0;
    int              n_fail = 0;
    int              stall_err = 0;
    int              stall_seen = 0;

    multi_channel_packet_merger #(
        .N_CH(N_CH), .DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_in_data(i_in_data), .i_in_vld(i_in_vld), .o_in_rdy(o_in_rdy),
        .dma_data(dma_data), .dma_ch(dma_ch), .dma_sop(dma_sop),
        .dma_eop(dma_eop), .dma_vld(dma_vld), .dma_rdy(dma_rdy),
        .i_mm_addr(i_mm_addr), .i_mm_rd(i_mm_rd), .i_mm_wr(i_mm_wr),
        .i_mm_wr_data(i_mm_wr_data), .o_mm_rd_data(o_mm_rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] wd(input logic s, input logic e,
                                        input logic [31:0] d);
        return {s, e, 2'b00, d};
    endfunction

    function automatic logic [63:0] bt(input beat_t b);
        return 64'({b.ch, b.sop, b.eop, b.data});
    endfunction

    function automatic logic [63:0] eb(input logic [1:0] c, input logic s,
                                       input logic e, input logic [31:0] d);
        return 64'({c, s, e, d});
    endfunction

    task automatic refresh();
        for (int c = 0; c < N_CH; c++) begin
            i_in_vld[c] = chq[c].size() > 0;
            i_in_data[c*W +: W] = (chq[c].size() > 0) ? chq[c][0] : '0;
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        #1;
        for (int c = 0; c < N_CH; c++)
            if (pop_mask[c] && chq[c].size() > 0)
                popped = chq[c].pop_front();
        refresh();
    end

    always @(negedge clk) begin
        pop_mask = o_in_rdy;
        if (o_in_rdy[0])
            rdy0_seen = 1'b1;
        if (rst_n && prev_stall &&
            {dma_ch, dma_sop, dma_eop, dma_data} !== prev_out)
            stall_err++;
        if (rst_n && dma_vld && !dma_rdy)
            stall_seen++;
        prev_stall = rst_n && dma_vld && !dma_rdy;
        prev_out   = {dma_ch, dma_sop, dma_eop, dma_data};
        if (rst_n && dma_vld && dma_rdy)
            obs.push_back('{ch: dma_ch, sop: dma_sop, eop: dma_eop,
                            data: dma_data, cyc: cyc});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        dma_rdy = 1'b1;
        for (int c = 0; c < N_CH; c++)
            chq[c].delete();
        refresh();
        tick();
        tick();
        rst_n = 1'b1;
        obs.delete();
    endtask

    task automatic mm_read(input logic [7:0] a, output logic [31:0] d);
        i_mm_addr = a;
        i_mm_rd = 1'b1;
        tick();
        i_mm_rd = 1'b0;
        d = o_mm_rd_data;
    endtask

    task automatic mm_write(input logic [7:0] a, input logic [31:0] d);
        i_mm_addr = a;
        i_mm_wr_data = d;
        i_mm_wr = 1'b1;
        tick();
        i_mm_wr = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (obs.size() < n && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_beats"}, 64'(obs.size() >= n), 64'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [63:0] exp2 [10];
        int t0, bad, eops, first_eop;

        // reset values
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_vld", 64'(dma_vld), 0);
        check("rst_rdy", 64'(o_in_rdy), 0);
        check("rst_rd", 64'(o_mm_rd_data), 0);
        rst_n = 1'b1;
        tick();
        mm_read(8'h01, d);
        check("rst_mask", 64'(d), 64'hF);

        // 3-word packet on ch0
        t0 = cyc;
        chq[0].push_back(wd(1, 0, 32'h100));
        chq[0].push_back(wd(0, 0, 32'h101));
        chq[0].push_back(wd(0, 1, 32'h102));
        refresh();
        wait_beats(3, 20, "t1");
        check("t1_lat", 64'(obs[0].cyc), 64'(t0 + 2));
        check("t1_b0", bt(obs[0]), eb(0, 1, 0, 32'h100));
        check("t1_b1", bt(obs[1]), eb(0, 0, 0, 32'h101));
        check("t1_b2", bt(obs[2]), eb(0, 0, 1, 32'h102));
        check("t1_contig", 64'(obs[2].cyc), 64'(t0 + 4));
        repeat (2) tick();
        mm_read(8'h10, d);
        check("t1_pkt0", 64'(d), 1);

        // round robin across all channels
        do_reset();
        chq[0].push_back(wd(1, 0, 32'hC000));
        chq[0].push_back(wd(0, 1, 32'hC001));
        chq[0].push_back(wd(1, 0, 32'hC008));
        chq[0].push_back(wd(0, 1, 32'hC009));
        for (int c = 1; c < N_CH; c++) begin
            chq[c].push_back(wd(1, 0, 32'hC000 + 32'(c * 16)));
            chq[c].push_back(wd(0, 1, 32'hC001 + 32'(c * 16)));
        end
        refresh();
        exp2 = '{eb(0, 1, 0, 32'hC000), eb(0, 0, 1, 32'hC001),
                 eb(1, 1, 0, 32'hC010), eb(1, 0, 1, 32'hC011),
                 eb(2, 1, 0, 32'hC020), eb(2, 0, 1, 32'hC021),
                 eb(3, 1, 0, 32'hC030), eb(3, 0, 1, 32'hC031),
                 eb(0, 1, 0, 32'hC008), eb(0, 0, 1, 32'hC009)};
        wait_beats(10, 60, "t2");
        for (int i = 0; i < 10; i++)
            check($sformatf("t2_b%0d", i), bt(obs[i]), exp2[i]);
        bad = 0;
        for (int p = 0; p < 5; p++) begin
            if (obs[2*p+1].cyc != obs[2*p].cyc + 1)
                bad++;
            if (p > 0 && obs[2*p].cyc != obs[2*p-1].cyc + 2)
                bad++;
        end
        check("t2_timing", 64'(bad), 0);

        // truncation at MAX_LEN
        do_reset();
        chq[1].push_back(wd(1, 0, 32'd0));
        for (int i = 1; i < 1029; i++)
            chq[1].push_back(wd(0, 0, 32'(i)));
        chq[1].push_back(wd(0, 1, 32'd1029));
        refresh();
        wait_beats(1024, 1200, "t3");
        repeat (15) tick();
        check("t3_count", 64'(obs.size()), 1024);
        bad = 0;
        eops = 0;
        first_eop = -1;
        for (int i = 0; i < obs.size(); i++) begin
            if (obs[i].data != 32'(i) || obs[i].ch != 2'd1 ||
                obs[i].sop != (i == 0))
                bad++;
            if (obs[i].eop) begin
                eops++;
                if (first_eop < 0)
                    first_eop = i;
            end
        end
        check("t3_data", 64'(bad), 0);
        check("t3_eops", 64'(eops), 1);
        check("t3_eop_pos", 64'(first_eop), 1023);
        mm_read(8'h16, d);
        check("t3_err1", 64'(d), 1);
        mm_read(8'h15, d);
        check("t3_drop1", 64'(d), 6);
        mm_read(8'h14, d);
        check("t3_pkt1", 64'(d), 1);
        mm_read(8'h02, d);
        check("t3_status", 64'(d), 64'h1);
        check("t3_drained", 64'(chq[1].size()), 0);

        // orphan drop and mid-packet sop
        do_reset();
        chq[2].push_back(wd(0, 0, 32'hDEAD));
        refresh();
        repeat (4) tick();
        check("t4_no_out", 64'(obs.size()), 0);
        check("t4_popped", 64'(chq[2].size()), 0);
        mm_read(8'h19, d);
        check("t4_drop2", 64'(d), 1);
        chq[2].push_back(wd(1, 0, 32'hA0));
        chq[2].push_back(wd(0, 0, 32'hA1));
        chq[2].push_back(wd(1, 0, 32'hA2));
        chq[2].push_back(wd(0, 1, 32'hA3));
        refresh();
        wait_beats(4, 20, "t4");
        check("t4_b0", bt(obs[0]), eb(2, 1, 0, 32'hA0));
        check("t4_b2", bt(obs[2]), eb(2, 0, 0, 32'hA2));
        check("t4_b3", bt(obs[3]), eb(2, 0, 1, 32'hA3));
        repeat (2) tick();
        mm_read(8'h1A, d);
        check("t4_err2", 64'(d), 1);
        mm_read(8'h18, d);
        check("t4_pkt2", 64'(d), 1);

        // backpressure 1010...
        do_reset();
        stall_err = 0;
        stall_seen = 0;
        for (int i = 0; i < 5; i++)
            chq[3].push_back(wd(i == 0, i == 4, 32'hB0 + 32'(i)));
        refresh();
        for (int k = 0; k < 40 && obs.size() < 5; k++) begin
            dma_rdy = (k % 2 == 0);
            tick();
        end
        dma_rdy = 1'b1;
        tick();
        check("t5_count", 64'(obs.size()), 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("t5_b%0d", i), bt(obs[i]),
                  eb(3, i == 0, i == 4, 32'hB0 + 32'(i)));
        check("t5_stable", 64'(stall_err), 0);
        check("t5_stalled", 64'(stall_seen > 0), 1);

        // reset in the middle of a packet
        obs.delete();
        for (int i = 0; i < 4; i++)
            chq[3].push_back(wd(i == 0, i == 3, 32'hC0 + 32'(i)));
        refresh();
        wait_beats(2, 20, "t5r");
        rst_n = 1'b0;
        tick();
        check("t5r_vld", 64'(dma_vld), 0);
        check("t5r_flags", 64'({dma_sop, dma_eop, dma_ch}), 0);
        check("t5r_data", 64'(dma_data), 0);
        check("t5r_rdy", 64'(o_in_rdy), 0);
        check("t5r_rd", 64'(o_mm_rd_data), 0);
        chq[3].delete();
        refresh();
        tick();
        rst_n = 1'b1;
        tick();
        mm_read(8'h01, d);
        check("t5r_mask", 64'(d), 64'hF);
        mm_read(8'h1C, d);
        check("t5r_pkt3", 64'(d), 0);
        mm_read(8'h1A, d);
        check("t5r_err2", 64'(d), 0);

        // enable mask and register map
        obs.delete();
        mm_write(8'h01, 32'h2);
        rdy0_seen = 1'b0;
        chq[0].push_back(wd(1, 0, 32'hE0));
        chq[0].push_back(wd(0, 1, 32'hE1));
        chq[1].push_back(wd(1, 0, 32'hF0));
        chq[1].push_back(wd(0, 1, 32'hF1));
        refresh();
        wait_beats(2, 20, "t6");
        repeat (6) tick();
        check("t6_count", 64'(obs.size()), 2);
        check("t6_b0", bt(obs[0]), eb(1, 1, 0, 32'hF0));
        check("t6_b1", bt(obs[1]), eb(1, 0, 1, 32'hF1));
        check("t6_no_rdy0", 64'(rdy0_seen), 0);
        check("t6_ch0_held", 64'(chq[0].size()), 2);
        mm_read(8'h01, d);
        check("t6_mask", 64'(d), 64'h2);
        mm_read(8'h00, d);
        check("t6_id", 64'(d), 64'hA5040400);
        mm_write(8'h00, 32'h12345678);
        mm_read(8'h00, d);
        check("t6_id_ro", 64'(d), 64'hA5040400);
        mm_read(8'h03, d);
        check("t6_unmapped", 64'(d), 0);
        mm_read(8'h1F, d);
        check("t6_cnt_hole", 64'(d), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_channel_packet_merger.md
Name: multi_channel_packet_merger

Overview:
Merges packet streams from N_CH receive channels (each already a 36-bit FIFO word stream in the system clock domain) into one DMA stream with sop/eop framing and a channel tag. Round-robin arbitration happens only at packet boundaries, and packet length is limited with forced truncation. An Avalon-MM slave provides per-channel statistics and a channel-enable mask. The block sits between the per-channel receive FIFOs and the DMA engine, and generalises the single-channel packet queue.

Parameters:
N_CH, 4, number of input channels (2..16)
DATA_W, 32, payload width; input word width is DATA_W+4
MAX_LEN, 1024, maximum packet length in words, including sop and eop words
CNT_W, 32, width of the statistics counters (<=32)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active low
i_in_data  in  N_CH*(DATA_W+4)  channel words packed, ch0 in the LSBs; per word: [DATA_W+3]=sop, [DATA_W+2]=eop, [DATA_W+1:DATA_W] reserved, [DATA_W-1:0]=payload
i_in_vld  in  N_CH  channel head word valid (FIFO not empty)
o_in_rdy  out  N_CH  pop the channel head word (FIFO rdreq, show-ahead)
dma_data  out  DATA_W  payload
dma_ch  out  $clog2(N_CH)  source channel of the current word
dma_sop  out  1  first word of packet
dma_eop  out  1  last word of packet
dma_vld  out  1  output valid
dma_rdy  in  1  downstream ready
i_mm_addr  in  8  word address
i_mm_rd  in  1  read strobe
i_mm_wr  in  1  write strobe
i_mm_wr_data  in  32  write data
o_mm_rd_data  out  32  read data, valid 1 cycle after i_mm_rd

Behaviour:
- Reset (synchronous, rst_n=0 sampled on the clk edge): state=IDLE, all dma_* outputs=0, o_in_rdy=0, o_mm_rd_data=0, last_grant=N_CH-1, enable mask=all ones, counters=0, len counter=0.
- Output register: free = ~dma_vld | dma_rdy. An input word is accepted (o_in_rdy[g]=1) only in a cycle where free=1. dma_vld drops when dma_rdy=1 and no new word is loaded. dma_* are held stable while dma_vld & ~dma_rdy.
- FSM:
  IDLE: an enabled channel whose head word has vld=1 and sop=0 is popped (orphan). Drop count +1 for that channel. Several channels may be popped in the same cycle. Among enabled channels with vld=1 and sop=1, the rr_arbiter picks the first after last_grant. The grant is registered; next state=PASS. No pop of the granted word this cycle.
  PASS: o_in_rdy[g] = i_in_vld[g] & free. Each accepted word loads the output register with dma_ch=g and increments len.
  - First word: dma_sop=1, len=1.
  - A later word carrying sop=1: sop is suppressed, error count[g] +1, and the word is forwarded.
  - A word with eop=1: dma_eop=1, pkt count[g] +1, last_grant=g, next state=IDLE.
  - The word with len==MAX_LEN and eop=0: forced dma_eop=1, error count[g] +1, pkt count[g] +1, last_grant=g, next state=DROP.
  - A single word with sop=1 and eop=1 is emitted as a 1-word packet with sop=1, eop=1.
  DROP: o_in_rdy[g]=i_in_vld[g] regardless of free. Each popped word increments drop count[g]. A popped word with eop=1 → IDLE. A popped word with sop=1 is also dropped.
- Latency: with IDLE, a sop word at cycle T, and dma_rdy=1: grant at the T+1 edge, pop in cycle T+1, dma_vld=1 from cycle T+2. Throughput in PASS is 1 word/cycle. Packet-to-packet gap is 1 cycle (the IDLE arbitration cycle).
- Clearing a channel's enable bit mid-packet does not abort the packet. It takes effect at the next arbitration.
- Counters saturate at all ones and do not wrap.
- Register map (read latency 1):
  - 0x00: ID {8'hA5, 8'(N_CH), 16'(MAX_LEN)}
  - 0x01: enable mask; R/W, low N_CH bits
  - 0x02: status {state[1:0], grant}
  - 0x10 + 4*ch + {0: pkt count, 1: drop count, 2: error count}
  - Unmapped addresses read 0. Writes to read-only addresses are ignored.
  - If a read and a counter increment happen in the same cycle, the read returns the pre-increment value.

Decomposition:
- Package mcpm_pkg holds: SOP/EOP bit offset functions of DATA_W, state enum {IDLE, PASS, DROP}, register address constants, and the ID constant.
- Sub-module rr_arbiter: combinational, parameter N; inputs req[N] and last[$clog2(N)]; outputs gnt_idx and any. Rotating priority starts at last+1.

Test Plan:
- Ch0 sends 3-word packet (sop, -, eop) with dma_rdy=1 → dma_vld at T+2, words contiguous, sop on word 1, eop on word 3, dma_ch=0, pkt count[0]=1.
- Ch0..ch3 all hold 2-word packets continuously → grant order 0,1,2,3,0, one idle cycle between packets, no interleaving of words within a packet.
- Ch1 sends 1030 words with no eop, MAX_LEN=1024 → word 1024 has dma_eop=1, error count[1]=1, 6 words dropped (drop count[1]=6), IDLE after the real eop.
- Ch2 head is a non-sop word while IDLE → popped without output, drop count[2]=1. A mid-packet sop → forwarded with dma_sop=0, error count[2]=1.
- dma_rdy toggled 1010… during a 5-word packet → no loss or duplication, dma_* stable while stalled. Assert rst_n=0 mid-packet → all outputs 0 next cycle, mask reads 0xF, counters read 0.
- Write mask 0x2 → only ch1 is granted. Ch0 sop head stays with o_in_rdy[0]=0. A read of 0x00 with N_CH=4, MAX_LEN=1024 returns 0xA5040400.
